hamming_dec: RTL and testbench

Pipelined single-error-correcting Hamming decoder, the receive-side counterpart of the team's `enc` block. It accepts N-bit codewords in the bit order that `enc` produces, computes the syndrome, and corrects any single-bit error. It then delivers the K data bits two cycles later, together with per-word error flags. Saturating error counters provide link-quality monitoring.

---
 rtl/hamming_dec.sv | 94 +++++++++
 tb/tb_hamming_dec.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec.sv
// hamming_dec: pipelined single-error-correcting Hamming decoder with saturating error counters
module hamming_dec #(
  parameter int K = 4,
  parameter int CNT_W = 16,
  localparam int R = K <= 1 ? 2 : K <= 4 ? 3 : K <= 11 ? 4 : K <= 26 ? 5 : K <= 57 ? 6 : K <= 120 ? 7 : 8,
  localparam int N = K + R
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic             din_val,
  input  logic             cnt_clr,
  output logic [K-1:0]     dout,
  output logic             dout_val,
  output logic             err_corr,
  output logic             err_unc,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_unc
);
  // codeword position (1-based) of data bit k: the k-th non-power-of-two position
  function automatic int dpos(int k);
    int c = 0;
    int r = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        if (c == k) r = p;
        c++;
      end
    return r;
  endfunction

  logic [N-1:0] s1_cw;
  logic [R-1:0] s1_syn;
  logic         s1_val;
  logic [R-1:0] syn;
  logic [N-1:0] fix;
  logic [K-1:0] data;
  logic         s_corr;
  logic         s_unc;

  // syndrome is the XOR of the indices of all set positions
  always_comb begin
    syn = '0;
    for (int i = 1; i <= N; i++) syn = din[i-1] ? syn ^ R'(i) : syn;
  end

  // classify the stage-1 syndrome and flip the addressed position
  always_comb begin
    s_corr = s1_syn != '0 && s1_syn <= R'(N);
    s_unc  = s1_syn > R'(N);
    fix    = s1_cw;
    for (int i = 1; i <= N; i++) fix[i-1] = (s_corr && s1_syn == R'(i)) ? ~s1_cw[i-1] : s1_cw[i-1];
  end

  for (genvar g = 0; g < K; g++) begin : g_data
    assign data[g] = fix[dpos(g)-1];
  end

  // stage 1: capture codeword and syndrome
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_val <= 1'b0;
      s1_cw  <= '0;
      s1_syn <= '0;
    end else begin
      s1_val <= din_val;
      s1_cw  <= din_val ? din : s1_cw;
      s1_syn <= din_val ? syn : s1_syn;
    end

  // stage 2: corrected data and flags, held between words
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout_val <= 1'b0;
      dout     <= '0;
      err_corr <= 1'b0;
      err_unc  <= 1'b0;
    end else begin
      dout_val <= s1_val;
      dout     <= s1_val ? data : dout;
      err_corr <= s1_val ? s_corr : err_corr;
      err_unc  <= s1_val ? s_unc : err_unc;
    end

  // saturating link-quality counters; clear wins over increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_corr <= '0;
      cnt_unc  <= '0;
    end else begin
      cnt_corr <= cnt_clr ? '0 : (dout_val && err_corr && !(&cnt_corr)) ? cnt_corr + CNT_W'(1) : cnt_corr;
      cnt_unc  <= cnt_clr ? '0 : (dout_val && err_unc && !(&cnt_unc)) ? cnt_unc + CNT_W'(1) : cnt_unc;
    end
endmodule

// File: tb/tb_hamming_dec.sv
// tb_hamming_dec: scoreboard bench for hamming_dec (K=4/CNT_W=2 and K=8/CNT_W=16 instances)
module tb_hamming_dec;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0]  din4 = '0;
  logic        v4 = 0, clr4 = 0;
  logic [3:0]  dout4;
  logic        ov4, c4, u4;
  logic [1:0]  cc4, cu4;
  logic [11:0] din8 = '0;
  logic        v8 = 0, clr8 = 0;
  logic [7:0]  dout8;
  logic        ov8, c8, u8;
  logic [15:0] cc8, cu8;

  hamming_dec #(.K(4), .CNT_W(2)) d4 (
    .clk(clk), .rst(rst), .din(din4), .din_val(v4), .cnt_clr(clr4),
    .dout(dout4), .dout_val(ov4), .err_corr(c4), .err_unc(u4),
    .cnt_corr(cc4), .cnt_unc(cu4)
  );

  hamming_dec #(.K(8), .CNT_W(16)) d8 (
    .clk(clk), .rst(rst), .din(din8), .din_val(v8), .cnt_clr(clr8),
    .dout(dout8), .dout_val(ov8), .err_corr(c8), .err_unc(u8),
    .cnt_corr(cc8), .cnt_unc(cu8)
  );

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        u;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t l0, l1;
  int m0c, m0u, m1c, m1u;
  int n_chk = 0, n_err = 0;

  task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic int r_of(int k);
    int r = 1;
    while ((1 << r) < k + r + 1) r++;
    return r;
  endfunction

  // textbook encoder: data into non-power-of-two slots, even parity into slot 2^j
  function automatic logic [15:0] enc(int k, logic [15:0] d);
    int n = k + r_of(k);
    int di = 0;
    logic [15:0] c = '0;
    for (int p = 1; p <= n; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        di++;
      end
    for (int j = 0; (1 << j) <= n; j++) begin
      logic par;
      par = 0;
      for (int p = 1; p <= n; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par ^= c[p-1];
      c[(1 << j) - 1] = par;
    end
    return c;
  endfunction

  function automatic logic [15:0] ext(int k, logic [15:0] c);
    int n = k + r_of(k);
    int di = 0;
    logic [15:0] d = '0;
    for (int p = 1; p <= n; p++)
      if ((p & (p - 1)) != 0) begin
        d[di] = c[p-1];
        di++;
      end
    return d;
  endfunction

  // decode by search: a valid codeword, or the one single flip that yields one, else raw data
  function automatic exp_t ref_dec(int k, logic [15:0] c);
    exp_t e;
    int n = k + r_of(k);
    logic [15:0] t;
    e.d = ext(k, c);
    e.c = 0;
    e.u = 0;
    e.cyc = 0;
    if (enc(k, e.d) != c) begin
      e.u = 1;
      for (int p = 1; p <= n; p++) begin
        t = c ^ (16'd1 << (p - 1));
        if (enc(k, ext(k, t)) == t) begin
          e.d = ext(k, t);
          e.c = 1;
          e.u = 0;
        end
      end
    end
    return e;
  endfunction

  task automatic put(int i, logic [15:0] cw, exp_t e);
    @(posedge clk);
    #1;
    v4 = 0; v8 = 0; clr4 = 0; clr8 = 0;
    e.cyc = cyc;
    if (i == 0) begin din4 = cw[6:0]; v4 = 1; q0.push_back(e); end
    else begin din8 = cw[11:0]; v8 = 1; q1.push_back(e); end
  endtask

  task automatic word(int i, logic [15:0] cw);
    put(i, cw, ref_dec(i == 0 ? 4 : 8, cw));
  endtask

  task automatic word_x(int i, logic [15:0] cw, logic [15:0] d, logic c, logic u);
    exp_t e;
    e.d = d; e.c = c; e.u = u; e.cyc = 0;
    put(i, cw, e);
  endtask

  task automatic idle(int n, int clrm = 0);
    repeat (n) begin
      @(posedge clk);
      #1;
      v4 = 0; v8 = 0;
      clr4 = clrm[0];
      clr8 = clrm[1];
    end
  endtask

  // monitor: pop on every dout_val, check held outputs and counter model each cycle
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete(); q1.delete();
      l0 = '{d: 0, c: 0, u: 0, cyc: 0};
      l1 = '{d: 0, c: 0, u: 0, cyc: 0};
      m0c = 0; m0u = 0; m1c = 0; m1u = 0;
    end
    if (ov4) begin
      if (q0.size() == 0) cmp("extra word k4", ov4, 0);
      else begin l0 = q0.pop_front(); cmp("latency k4", cyc - l0.cyc, 2); end
    end
    if (ov8) begin
      if (q1.size() == 0) cmp("extra word k8", ov8, 0);
      else begin l1 = q1.pop_front(); cmp("latency k8", cyc - l1.cyc, 2); end
    end
    cmp("dout k4", dout4, l0.d);
    cmp("err_corr k4", c4, l0.c);
    cmp("err_unc k4", u4, l0.u);
    cmp("cnt_corr k4", cc4, m0c);
    cmp("cnt_unc k4", cu4, m0u);
    cmp("dout k8", dout8, l1.d);
    cmp("err_corr k8", c8, l1.c);
    cmp("err_unc k8", u8, l1.u);
    cmp("cnt_corr k8", cc8, m1c);
    cmp("cnt_unc k8", cu8, m1u);
    m0c = (!rst || clr4) ? 0 : (ov4 && l0.c && m0c < 3) ? m0c + 1 : m0c;
    m0u = (!rst || clr4) ? 0 : (ov4 && l0.u && m0u < 3) ? m0u + 1 : m0u;
    m1c = (!rst || clr8) ? 0 : (ov8 && l1.c && m1c < 65535) ? m1c + 1 : m1c;
    m1u = (!rst || clr8) ? 0 : (ov8 && l1.u && m1u < 65535) ? m1u + 1 : m1u;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset dout_val", ov4, 0);
    cmp("reset dout", dout4, 0);
    cmp("reset cnt_corr", cc4, 0);
    rst = 1;
    // clean sweep plus spot codewords
    for (int d = 0; d < 16; d++) word(0, enc(4, 16'(d)));
    word_x(0, 16'b1010101, 16'b1011, 0, 0);
    word_x(0, 16'b1111111, 16'b1111, 0, 0);
    idle(3);
    cmp("clean cnt_corr", cc4, 0);
    // single error at position 5
    word_x(0, 16'b1000101, 16'b1011, 1, 0);
    idle(3);
    cmp("single cnt_corr", cc4, 1);
    for (int p = 1; p <= 7; p++) word(0, enc(4, 16'($urandom_range(0, 15))) ^ (16'd1 << (p - 1)));
    // double error aliases to a correction; K=8 uncorrectable syndrome 13
    word_x(0, 16'b1010110, 16'b1010, 1, 0);
    word_x(1, 16'h801, 16'h80, 0, 1);
    idle(3);
    cmp("unc cnt_unc", cu8, 1);
    cmp("unc cnt_corr", cc8, 0);
    // saturation and clear-over-increment
    idle(1, 1);
    idle(2);
    cmp("cleared cnt_corr", cc4, 0);
    repeat (5) word(0, enc(4, 16'($urandom_range(0, 15))) ^ (16'd1 << $urandom_range(0, 6)));
    idle(4);
    cmp("saturated cnt_corr", cc4, 3);
    word(0, enc(4, 16'($urandom_range(0, 15))) ^ 16'd4);
    idle(1);
    idle(1, 1);
    idle(3);
    cmp("clr priority cnt_corr", cc4, 0);
    // gap in din_val
    word(0, enc(4, 16'd5));
    idle(1);
    word(0, enc(4, 16'd10) ^ 16'd1);
    idle(4);
    // reset with two words in flight
    word(0, enc(4, 16'd3));
    word(0, enc(4, 16'd9));
    #1 rst = 0;
    #1;
    v4 = 0;
    cmp("midrst dout_val", ov4, 0);
    cmp("midrst dout", dout4, 0);
    cmp("midrst err_corr", c4, 0);
    cmp("midrst cnt_corr", cc4, 0);
    idle(2);
    rst = 1;
    word(0, enc(4, 16'd6) ^ 16'd64);
    idle(4);
    // randomized traffic on both instances
    repeat (200) begin
      int i, k, nf;
      logic [15:0] cw;
      i = int'($urandom_range(0, 1));
      k = i == 1 ? 8 : 4;
      cw = enc(k, 16'($urandom_range(0, (1 << k) - 1)));
      nf = int'($urandom_range(0, 2));
      for (int f = 0; f < nf; f++) cw ^= 16'd1 << $urandom_range(0, k + r_of(k) - 1);
      if (i == 1 && $urandom_range(0, 3) == 0) cw = 16'($urandom_range(0, 4095));
      if ($urandom_range(0, 4) == 0) idle(1);
      word(i, cw);
    end
    idle(1);
    for (int t = 0; t < 20 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
    cmp("drain pending words", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
